// File: rtl/duty_cycle_meter_mc.sv
// Multi-channel duty cycle meter: counts synchronised high cycles per channel over a
// WINDOW-cycle measurement window. Optional rising-edge counting under DUTY_EDGE_COUNT_EN.
module duty_cycle_meter_mc #(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = 16,
  parameter int WINDOW      = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       ring_in,
  input  logic                      enable,
  input  logic                      ack,
  output logic [CHANNELS*CNT_W-1:0] value,
  output logic                      valid,
  output logic                      overrun,
`ifdef DUTY_EDGE_COUNT_EN
  output logic [CHANNELS*CNT_W-1:0] edges,
  output logic                      busy
`else
  output logic                      busy
`endif
);

  localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int FW = (SYNC_STAGES > 1) ? $clog2(SYNC_STAGES) : 1;
  localparam logic [WW-1:0] W_LAST = WW'(WINDOW - 1);
  localparam logic [FW-1:0] F_LAST = FW'(SYNC_STAGES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_MEAS  = 2'd2;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic b);
    if (&a) return a;
    return a + CNT_W'(b);
  endfunction

  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
  logic [CHANNELS-1:0]                  s;
  logic [1:0]                           state_q, state_d;
  logic [FW-1:0]                        fc_q, fc_d;
  logic [WW-1:0]                        w_q, w_d;
  logic [CHANNELS-1:0][CNT_W-1:0]       hc_q, hc_d, hc_inc;
  logic [CHANNELS-1:0][CNT_W-1:0]       val_q, val_d;
  logic                                 valid_q, valid_d;
  logic                                 ovr_q, ovr_d;
  logic                                 win_end;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) hc_inc[i] = sat_add(hc_q[i], s[i]);
  end

  // The final window cycle folds its own sample into the published result.
  assign win_end = (state_q == S_MEAS) && enable && (w_q == W_LAST);

  always_comb begin
    state_d = state_q;
    fc_d    = '0;
    w_d     = w_q;
    hc_d    = hc_q;
    case (state_q)
      S_IDLE: begin
        w_d  = '0;
        hc_d = '0;
        if (enable) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (!enable) state_d = S_IDLE;
        else if (fc_q == F_LAST) begin
          state_d = S_MEAS;
          w_d     = '0;
        end else fc_d = fc_q + FW'(1);
      end
      S_MEAS: begin
        if (!enable) begin
          state_d = S_IDLE;
          w_d     = '0;
          hc_d    = '0;
        end else if (w_q == W_LAST) begin
          w_d  = '0;
          hc_d = '0;
        end else begin
          w_d  = w_q + WW'(1);
          hc_d = hc_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A completing window beats a simultaneous ack: the ack only retires the old result.
  always_comb begin
    val_d   = val_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (win_end) begin
      val_d   = hc_inc;
      valid_d = 1'b1;
      ovr_d   = valid_q & ~ack;
    end else if (valid_q && ack) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      state_q <= S_IDLE;
      fc_q    <= '0;
      w_q     <= '0;
      hc_q    <= '0;
      val_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], ring_in};
      state_q <= state_d;
      fc_q    <= fc_d;
      w_q     <= w_d;
      hc_q    <= hc_d;
      val_q   <= val_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign value   = val_q;
  assign valid   = valid_q;
  assign overrun = ovr_q;
  assign busy    = (state_q == S_FLUSH) || (state_q == S_MEAS);

`ifdef DUTY_EDGE_COUNT_EN
  logic [CHANNELS-1:0]            prev_q;
  logic [CHANNELS-1:0][CNT_W-1:0] ec_q, ec_d, ec_inc, edg_q, edg_d;

  // prev_q tracks s every cycle, so the first MEASURE cycle sees the last FLUSH sample.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) ec_inc[i] = sat_add(ec_q[i], s[i] & ~prev_q[i]);
    ec_d  = '0;
    edg_d = edg_q;
    if (state_q == S_MEAS && enable) begin
      if (w_q == W_LAST) edg_d = ec_inc;
      else ec_d = ec_inc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q <= '0;
      ec_q   <= '0;
      edg_q  <= '0;
    end else begin
      prev_q <= s;
      ec_q   <= ec_d;
      edg_q  <= edg_d;
    end
  end

  assign edges = edg_q;
`endif

endmodule

// File: tb/tb_duty_cycle_meter_mc.sv
// Randomised and directed bench for duty_cycle_meter_mc against a window-sum reference model.
module tb_duty_cycle_meter_mc;
  localparam int CH  = 4;
  localparam int CW  = 16;
  localparam int WIN = 16;
  localparam int SS  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, enable, ack;
  logic [CH-1:0]     ring_in;
  logic [CH*CW-1:0]  value;
  logic              valid, overrun, busy;

  logic              s_en, s_ack;
  logic [0:0]        s_ring;
  logic [3:0]        s_value;
  logic              s_valid, s_overrun, s_busy;
`ifdef DUTY_EDGE_COUNT_EN
  logic [CH*CW-1:0]  edges;
  logic [3:0]        s_edges;
`endif

  duty_cycle_meter_mc #(.CHANNELS(CH), .CNT_W(CW), .WINDOW(WIN), .SYNC_STAGES(SS)) u_dut (
    .clk(clk), .reset(reset), .ring_in(ring_in), .enable(enable), .ack(ack),
    .value(value), .valid(valid), .overrun(overrun),
`ifdef DUTY_EDGE_COUNT_EN
    .edges(edges),
`endif
    .busy(busy));

  duty_cycle_meter_mc #(.CHANNELS(1), .CNT_W(4), .WINDOW(20), .SYNC_STAGES(2)) u_sat (
    .clk(clk), .reset(reset), .ring_in(s_ring), .enable(s_en), .ack(s_ack),
    .value(s_value), .valid(s_valid), .overrun(s_overrun),
`ifdef DUTY_EDGE_COUNT_EN
    .edges(s_edges),
`endif
    .busy(s_busy));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: pin history plus run start; results are plain sums over the window.
  logic [CH-1:0] hist [0:2047];
  int            k = 0;
  bit            m_active = 0;
  int            m_start = 0;
  bit            m_valid = 0, m_over = 0;
  logic [63:0]   m_value = '0, m_edges = '0;

  function automatic bit will_complete();
    return m_active && enable && (k - m_start >= SS + WIN) && ((k - m_start - SS) % WIN == 0);
  endfunction

  task automatic model_edge();
    hist[k] = ring_in;
    if (will_complete()) begin
      for (int c = 0; c < CH; c++) begin
        int sum, ed;
        sum = 0;
        ed  = 0;
        for (int j = k - SS - WIN + 1; j <= k - SS; j++) begin
          sum += int'(hist[j][c]);
          if (hist[j][c] && !hist[j-1][c]) ed++;
        end
        m_value[c*CW +: CW] = (sum > 65535) ? 16'hFFFF : 16'(sum);
        m_edges[c*CW +: CW] = (ed > 65535) ? 16'hFFFF : 16'(ed);
      end
      m_over  = m_valid && !ack;
      m_valid = 1'b1;
    end else if (ack && m_valid) begin
      m_valid = 1'b0;
      m_over  = 1'b0;
    end
    if (m_active && !enable) m_active = 1'b0;
    else if (!m_active && enable) begin
      m_active = 1'b1;
      m_start  = k;
    end
    k++;
  endtask

  task automatic compare();
    check_eq("valid", valid, m_valid);
    check_eq("overrun", overrun, m_over);
    check_eq("busy", busy, m_active);
    check_eq("value", value, m_value);
`ifdef DUTY_EDGE_COUNT_EN
    check_eq("edges", edges, m_edges);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic drive_pattern();
    ring_in = {(k % 4 == 0), k[0], 1'b0, 1'b1};
  endtask

  initial begin
    int n, opp, off_cnt;
    bit hit;
    logic [63:0] saved_v;
    logic saved_valid;

    reset = 1'b0; enable = 1'b0; ack = 1'b0; ring_in = '0;
    s_en = 1'b0; s_ack = 1'b0; s_ring = 1'b1;
    #12;
    check_eq("rst_value", value, 64'd0);
    check_eq("rst_valid", valid, 64'd0);
    check_eq("rst_overrun", overrun, 64'd0);
    check_eq("rst_busy", busy, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Fixed pattern, ack held low: first result and an overrun window.
    enable = 1'b1;
    for (int c = 0; c < 40; c++) begin
      drive_pattern();
      step();
      if (c == 17) check_eq("pre_valid", valid, 64'd0);
      if (c == 18) begin
        check_eq("first_valid", valid, 64'd1);
        check_eq("first_value", value, 64'h0004_0008_0000_0010);
`ifdef DUTY_EDGE_COUNT_EN
        check_eq("first_edges_ch2", edges[2*CW +: CW], 64'd8);
`endif
      end
      if (c == 34) begin
        check_eq("ovr_set", overrun, 64'd1);
        check_eq("ovr_value", value, 64'h0004_0008_0000_0010);
      end
    end

    // Single-cycle ack, then the next result arrives on the window cadence.
    ack = 1'b1; drive_pattern(); step(); ack = 1'b0;
    check_eq("ack_valid", valid, 64'd0);
    check_eq("ack_overrun", overrun, 64'd0);
    n = 0;
    do begin drive_pattern(); step(); n++; end while (!valid && n < 40);
    check_eq("revalid_edge", 64'(k - 1), 64'd50);

    // Ack on the completing cycle, second opportunity so overrun was set.
    opp = 0;
    for (int i = 0; i < 60 && opp < 2; i++) begin
      drive_pattern();
      hit = will_complete() && valid;
      if (hit) opp++;
      ack = hit && (opp == 2);
      step();
      if (ack) begin
        check_eq("coinc_valid", valid, 64'd1);
        check_eq("coinc_overrun", overrun, 64'd0);
        check_eq("coinc_value", value, 64'h0004_0008_0000_0010);
      end
      ack = 1'b0;
    end
    check_eq("coinc_seen", 64'(opp), 64'd2);

    // Drop enable at w==7 for 5 cycles; outputs hold, restart takes a full flush.
    ack = 1'b1; drive_pattern(); step(); ack = 1'b0;
    n = 0;
    while (((k - m_start - SS - 1) % WIN != 7) && n < 40) begin drive_pattern(); step(); n++; end
    saved_v = value; saved_valid = valid;
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin drive_pattern(); step(); end
    check_eq("drop_value", value, saved_v);
    check_eq("drop_valid", valid, 64'(saved_valid));
    check_eq("drop_busy", busy, 64'd0);
    enable = 1'b1;
    n = 0;
    do begin drive_pattern(); step(); n++; end while (!valid && n < 40);
    check_eq("reenable_lat", 64'(n), 64'd19);

    // Random traffic with random acks and enable drops.
    off_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      ring_in = CH'($urandom);
      ack = ($urandom_range(0, 7) == 0);
      if (off_cnt > 0) begin off_cnt--; enable = 1'b0; end
      else if ($urandom_range(0, 59) == 0) begin off_cnt = $urandom_range(1, 6); enable = 1'b0; end
      else enable = 1'b1;
      step();
    end

    // Asynchronous reset mid-measurement with a result pending.
    enable = 1'b1; ack = 1'b0;
    n = 0;
    do begin ring_in = CH'($urandom); step(); n++; end
    while (!(valid && m_active && (k - m_start > SS + 1)) && n < 80);
    #3 reset = 1'b0;
    #1;
    check_eq("arst_value", value, 64'd0);
    check_eq("arst_valid", valid, 64'd0);
    check_eq("arst_overrun", overrun, 64'd0);
    check_eq("arst_busy", busy, 64'd0);
    m_active = 1'b0; m_valid = 1'b0; m_over = 1'b0; m_value = '0; m_edges = '0;
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    do begin ring_in = CH'($urandom); step(); n++; end while (!valid && n < 40);
    check_eq("arst_relat", 64'(n), 64'd19);

    // Narrow counter saturates instead of wrapping.
    s_en = 1'b1;
    for (int i = 0; i < 23; i++) begin
      ring_in = CH'($urandom);
      step();
      if (i == 21) check_eq("sat_pre_valid", s_valid, 64'd0);
    end
    check_eq("sat_valid", s_valid, 64'd1);
    check_eq("sat_value", s_value, 64'd15);
`ifdef DUTY_EDGE_COUNT_EN
    check_eq("sat_edges", s_edges, 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/duty_cycle_meter_mc.md
Name: duty_cycle_meter_mc

Overview:
Multi-channel, parametrised successor to the single-channel duty cycle circuit. Measures the high time of CHANNELS asynchronous ring/PWM inputs over a programmable window of clk cycles. Publishes the per-channel high-cycle counts, with a valid/ack handshake and overrun detection. Sits between the ring oscillator / PWM sources and the display controller readout.

Parameters:
CHANNELS, 4, number of independent input channels
CNT_W, 16, width of each per-channel result; must satisfy 2^CNT_W-1 >= WINDOW, otherwise results saturate
WINDOW, 1024, measurement window length in clk cycles (>=2)
SYNC_STAGES, 2, flip-flop synchroniser depth per input (>=2)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
ring_in  input  CHANNELS  asynchronous channel inputs, bit i = channel i
enable  input  1  1 = measure continuously; 0 = stop and discard partial window
ack  input  1  consumer acknowledge; clears valid and overrun
value  output  CHANNELS*CNT_W  latched high-cycle counts, channel i at [i*CNT_W +: CNT_W]
valid  output  1  new results available; level, held until ack
overrun  output  1  sticky: a window completed while valid was still 1
busy  output  1  1 while the FSM is in FLUSH or MEASURE

Behaviour:
- Reset (reset=0, async): value=0, valid=0, overrun=0, busy=0, FSM=IDLE, synchronisers, window counter and high counters all 0.
- Each ring_in bit passes through a SYNC_STAGES flop chain; only the synchronised bit s[i] is counted. Pin-to-counter latency = SYNC_STAGES cycles.
- FSM states:
  - IDLE: counters held at 0. enable=1 -> FLUSH.
  - FLUSH: lasts SYNC_STAGES cycles to purge stale synchroniser contents; nothing counted. Then -> MEASURE.
  - MEASURE: window counter w runs 0..WINDOW-1; each cycle hc[i] += s[i].
- On the cycle w==WINDOW-1: value[i] <= hc[i]+s[i] (saturating at 2^CNT_W-1), hc[i] <= 0, w <= 0, FSM stays in MEASURE. No dead cycle between windows.
- valid rises on the clk edge that loads value, i.e. the cycle after w==WINDOW-1. First valid appears SYNC_STAGES+WINDOW cycles after enable is sampled 1.
- ack=1 while valid=1: valid <= 0 and overrun <= 0 on the next edge. ack while valid=0 has no effect.
- Window completes while valid=1 and ack=0: value is overwritten with the new result, valid stays 1, overrun <= 1.
- Window completes in the same cycle as ack: the new result wins. valid stays 1 and overrun <= 0; the ack consumes only the old result.
- enable=0 in FLUSH or MEASURE: next state IDLE, w and hc cleared, partial window discarded. value, valid and overrun hold.
- enable re-asserted: always restarts with a full FLUSH.
- Arithmetic: hc is CNT_W bits and saturates, never wraps. s[i]=1 for the whole window gives min(WINDOW, 2^CNT_W-1).
- Channels are fully independent in data; all channels share one window counter and one FSM.

Optional Feature:
DUTY_EDGE_COUNT_EN.
- Defined: adds output edges (CHANNELS*CNT_W). Per channel, rising edges of s[i] inside the window are counted, saturating at 2^CNT_W-1, and latched and handshaken together with value, giving a frequency estimate.
  - An edge is a 0->1 transition of s[i] between consecutive MEASURE cycles.
  - The first MEASURE cycle of a run (after FLUSH) compares against the last FLUSH sample.
  - Window boundaries do not lose edges: an edge on the last window cycle belongs to the ending window.
- Not defined: port absent; no edge logic.

Test Plan:
- Set CHANNELS=4, WINDOW=16, SYNC_STAGES=2. Drive ch0=1, ch1=0, ch2 toggling every clk, ch3 high 1 of every 4 clks. enable=1 at cycle 0, ack held 0 -> valid at cycle 18; value = {4, 8, 0, 16} (ch3..ch0). Next window at cycle 34 sets overrun=1 with identical value.
- Pulse ack for one cycle after the first valid -> valid=0 and overrun=0 next cycle; valid returns 16 cycles after the previous valid.
- Assert ack on exactly the cycle a window completes, with valid=1 -> valid stays 1, overrun stays 0, value updated.
- Drop enable at w=7, re-raise 5 cycles later -> value/valid unchanged; next valid arrives 2+16 cycles after re-enable; value reflects only the new window.
- Set CNT_W=4, WINDOW=20, ch0=1 -> value[3:0]=15 (saturated), no wrap.
- Pull reset low mid-MEASURE with valid=1 -> all outputs 0 immediately (asynchronous); after release with enable=1, first valid arrives 18 cycles later. With DUTY_EDGE_COUNT_EN, ch2 in the first test gives edges=8.
